// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared types, widths and constants for the binary32 add/sub sequencer
package fp_addsub_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int SUM_W = EXT_W + 1;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_t;

    // denormals flush to a signed zero: exponent 0 always yields a zero significand
    function automatic fp_t unpack(input logic [31:0] v, input logic s);
        fp_t r;
        r.sign = s;
        r.exp  = v[30:23];
        r.sig  = (v[30:23] == '0) ? '0 : {1'b1, v[22:0]};
        return r;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter over the 28-bit sum (28 when all zero)
//   in_v : word to scan
//   cnt  : number of leading zeros
module fp_lzc
    import fp_addsub_pkg::*;
(
    input  logic [SUM_W-1:0] in_v,
    output logic [4:0]       cnt
);
    always_comb begin
        cnt = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++)
            if (in_v[i]) cnt = 5'(SUM_W - 1 - i);
    end
endmodule

// File: rtl/fp_addsub_ctrl.sv
// fp_addsub_ctrl: multi-cycle binary32 add/sub sequencer (IDLE, ALIGN, ADD, NORM, ROUND, DONE)
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake for a, b, op (op=1 a+b, op=0 a-b)
//   out_valid/out_ready  : result handshake for result and flags {invalid, overflow, underflow}
//   FP_ADDSUB_RNE_EN     : defined = round-to-nearest-even, undefined = truncate
module fp_addsub_ctrl
    import fp_addsub_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);
`ifdef FP_ADDSUB_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif
    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [31:0]      result_q, result_d;
    logic [2:0]       flags_q, flags_d;
    fp_t              x_q, x_d, y_q, y_d;
    logic             sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
    logic [9:0]       exp_q, exp_d;
    logic [EXT_W-1:0] mx_q, mx_d, my_q, my_d, fld_q, fld_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    fp_t              ua, ub, big, sml;
    logic             a_nan, b_nan, a_inf, b_inf, clash, x_ge, lost, rup, ovf, unf;
    logic [31:0]      spec_res;
    logic [EXP_W-1:0] diff;
    logic [EXT_W-1:0] sfull, shifted, shl;
    logic [4:0]       lzc;
    logic [SIG_W:0]   man;
    logic [9:0]       ex_r;
    logic [MAN_W-1:0] frac;

    fp_lzc u_lzc (.in_v(sum_q), .cnt(lzc));

    assign ua       = unpack(a, a[31]);
    assign ub       = unpack(b, op ? b[31] : ~b[31]);
    assign a_nan    = (&a[30:23]) & (|a[22:0]);
    assign b_nan    = (&b[30:23]) & (|b[22:0]);
    assign a_inf    = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf    = (&b[30:23]) & ~(|b[22:0]);
    assign clash    = a_inf & b_inf & (a[31] ^ ub.sign);
    assign spec_res = (a_nan | b_nan | clash) ? QNAN : {a_inf ? a[31] : ub.sign, 8'hFF, 23'd0};

    assign x_ge    = {x_q.exp, x_q.sig} >= {y_q.exp, y_q.sig};
    assign big     = x_ge ? x_q : y_q;
    assign sml     = x_ge ? y_q : x_q;
    assign diff    = big.exp - sml.exp;
    assign sfull   = {sml.sig, 3'b000};
    assign shifted = sfull >> diff;
    // the mask covers every bit pushed out, so shifts of 27 or more fold the whole significand into sticky
    assign lost    = |(sfull & ((EXT_W'(1) << diff) - EXT_W'(1)));

    // without a carry the hidden bit sits at bit 26, so the left shift is one less than lzc
    assign shl = EXT_W'(sum_q << (lzc - 5'd1));

    assign rup  = RNE & fld_q[2] & (fld_q[3] | (|fld_q[1:0]));
    assign man  = {1'b0, fld_q[EXT_W-1:3]} + (SIG_W+1)'(rup);
    assign ex_r = exp_q + 10'(man[SIG_W]);
    assign frac = man[SIG_W] ? man[MAN_W:1] : man[MAN_W-1:0];
    assign ovf  = ~ex_r[9] & (ex_r >= 10'(EXP_MAX));
    assign unf  = ex_r[9] | (ex_r == '0);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        x_d         = x_q;
        y_d         = y_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        zero_d      = zero_q;
        exp_d       = exp_q;
        mx_d        = mx_q;
        my_d        = my_q;
        sum_d       = sum_q;
        fld_d       = fld_q;
        case (state_q)
            IDLE: if (in_valid & in_ready_q) begin
                in_ready_d = 1'b0;
                if (a_nan | b_nan | a_inf | b_inf) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = spec_res;
                    flags_d     = {clash, 2'b00};
                end else begin
                    state_d = ALIGN;
                    x_d     = ua;
                    y_d     = ub;
                end
            end
            ALIGN: begin
                state_d = ADD;
                sign_d  = big.sign;
                sub_d   = big.sign ^ sml.sign;
                exp_d   = {2'b00, big.exp};
                mx_d    = {big.sig, 3'b000};
                my_d    = {shifted[EXT_W-1:1], shifted[0] | lost};
            end
            ADD: begin
                state_d = NORM;
                sum_d   = sub_q ? {1'b0, mx_q} - {1'b0, my_q} : {1'b0, mx_q} + {1'b0, my_q};
            end
            NORM: begin
                state_d = ROUND;
                fld_d   = sum_q[SUM_W-1] ? {sum_q[SUM_W-1:2], |sum_q[1:0]} : shl;
                exp_d   = exp_q + 10'd1 - 10'(lzc);
                zero_d  = sum_q == '0;
            end
            ROUND: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                // an exact cancellation gives +0; only two like-signed zeros keep their sign
                result_d    = zero_q ? {sign_q & ~sub_q, 31'd0} :
                              ovf    ? {sign_q, 8'hFF, 23'd0} :
                              unf    ? {sign_q, 31'd0} : {sign_q, ex_r[7:0], frac};
                flags_d     = zero_q ? 3'b000 : {1'b0, ovf, unf};
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            sum_q       <= '0;
            fld_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            zero_q      <= zero_d;
            exp_q       <= exp_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            sum_q       <= sum_d;
            fld_q       <= fld_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// tb_fp_addsub_ctrl: directed vectors, random operands against an exact-arithmetic model, backpressure and reset abort
module tb_fp_addsub_ctrl;
`ifdef FP_ADDSUB_RNE_EN
    localparam logic [31:0] TIE = 32'h3F80_0002;
`else
    localparam logic [31:0] TIE = 32'h3F80_0001;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] a = '0, b = '0, result;
    logic [2:0]  flags;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    fp_addsub_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // exact sum on a common scale, then one rounding to 24 bits
    function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic               sx, sy, sg;
        int                 ex, ey, e0, p, e, sh;
        logic [23:0]        mx, my;
        logic signed [127:0] vx, vy, s;
        logic [127:0]       m, q, rem, half;
        sx = x[31];
        sy = o ? y[31] : ~y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return {3'b000, 32'h7FC0_0000};
        if (ex == 255 && ey == 255) return (sx == sy) ? {3'b000, sx, 8'hFF, 23'd0} : {3'b100, 32'h7FC0_0000};
        if (ex == 255) return {3'b000, sx, 8'hFF, 23'd0};
        if (ey == 255) return {3'b000, sy, 8'hFF, 23'd0};
        mx = (ex == 0) ? 24'd0 : {1'b1, x[22:0]};
        my = (ey == 0) ? 24'd0 : {1'b1, y[22:0]};
        e0 = ((ex > ey) ? ex : ey) - 62;
        // an operand far below the other only matters as a nonzero crumb
        vx = (mx == 0) ? 128'sd0 : (ex < e0) ? 128'sd1 : $signed({104'd0, mx}) <<< (ex - e0);
        vy = (my == 0) ? 128'sd0 : (ey < e0) ? 128'sd1 : $signed({104'd0, my}) <<< (ey - e0);
        if (sx) vx = -vx;
        if (sy) vy = -vy;
        s = vx + vy;
        if (s == 0) return {3'b000, (mx == 0 && my == 0 && sx == sy) ? sx : 1'b0, 31'd0};
        sg = s < 0;
        m = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        sh = p - 23;
        q = m >> sh;
        rem = m - (q << sh);
        half = 128'd1 << (sh - 1);
        e = p + e0 - 23;
`ifdef FP_ADDSUB_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
`else
        if (rem > half) q = q;
`endif
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {3'b010, sg, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, sg, 31'd0};
        return {3'b000, sg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input int near);
        int k, t;
        logic [22:0] f;
        k = int'($urandom_range(0, 19));
        f = 23'($urandom);
        if (k == 0) return {1'($urandom), 8'd0, $urandom_range(0, 1) ? f : 23'd0};
        if (k == 1) return {1'($urandom), 8'hFF, $urandom_range(0, 1) ? f : 23'd0};
        if (k == 2) return {1'($urandom), 8'd254, f};
        if (k == 3) return {1'($urandom), 8'd1, f};
        t = (k < 14) ? near + int'($urandom_range(0, 60)) - 30 : int'($urandom_range(1, 254));
        t = (t < 1) ? 1 : (t > 254) ? 254 : t;
        return {1'($urandom), 8'(t), f};
    endfunction

    task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic top, input int hold,
                       output logic [31:0] r, output logic [2:0] f, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        a = ta;
        b = tb;
        op = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = ~op;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = flags;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", result, r);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r, av, bv;
        logic [2:0]  f;
        logic [34:0] m;
        logic        ov;
        int          lat;
        vec_t        v[$];
        v.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 3'b000, 5});
        v.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 3'b000, 5});
        v.push_back('{32'h4000_0000, 32'h4040_0000, 1'b0, 32'hBF80_0000, 3'b000, 5});
        v.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 1});
        v.push_back('{32'h3F80_0001, 32'h3380_0000, 1'b1, TIE,           3'b000, 5});
        v.push_back('{32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 3'b000, 1});
        v.push_back('{32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 3'b000, 1});
        v.push_back('{32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'h7F80_0000, 3'b000, 1});
        v.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 3'b000, 1});
        v.push_back('{32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 1});
        v.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, 3'b010, 5});
        v.push_back('{32'h0080_0000, 32'h00C0_0000, 1'b0, 32'h8000_0000, 3'b001, 5});
        v.push_back('{32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 5});
        v.push_back('{32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h0000_0000, 3'b000, 5});
        v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 3'b000, 5});
        v.push_back('{32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hC040_0000, 3'b000, 5});

        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            run(v[i].a, v[i].b, v[i].op, (i == 0) ? 3 : 0, r, f, lat);
            chk($sformatf("vec%0d_result", i), r, v[i].res);
            chk($sformatf("vec%0d_flags", i), 32'(f), 32'(v[i].flg));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
        end

        @(negedge clk);
        a = 32'h3F80_0000;
        b = 32'h4000_0000;
        op = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_resume", 32'(out_valid), 32'd0);
        run(32'h3F80_0000, 32'h4000_0000, 1'b1, 0, r, f, lat);
        chk("after_abort_result", r, 32'h4040_0000);
        chk("after_abort_latency", 32'(lat), 32'd5);

        for (int n = 0; n < 300; n++) begin
            av = rnd_op(int'($urandom_range(1, 254)));
            bv = rnd_op(int'(av[30:23]));
            if ($urandom_range(0, 9) == 0) bv = av ^ {1'($urandom), 31'd0};
            ov = 1'($urandom);
            m = ref_model(av, bv, ov);
            run(av, bv, ov, int'($urandom_range(0, 2)), r, f, lat);
            chk($sformatf("rnd%0d_result %h %h op%0d", n, av, bv, ov), r, m[31:0]);
            chk($sformatf("rnd%0d_flags", n), 32'(f), 32'(m[34:32]));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), (&av[30:23] || &bv[30:23]) ? 32'd1 : 32'd5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
